// File: rtl/master_drain_fifo_control.sv
// ----------------------------------------------------------------------------
// master_drain_fifo_control
//
// Drain-side controller for the weight FIFOs. After the fill side has loaded a
// complete tile, this block pops the column FIFOs into the systolic array's
// weight shadow registers, one row per cycle. After the last row it pulses a
// swap so the array adopts the new weights. It is sequenced by the top-level
// master FSM through start/done.
//
// Ports
//   clk            clock, all state updates on posedge
//   reset          synchronous active-low reset (0 = reset)
//   start          request one drain of the loaded tile
//   done           high while idle and able to accept start
//   num_col        active columns minus one (0..COLS-1 -> 1..COLS columns)
//   fill_done      FIFOs hold a complete tile (fill side idle)
//   hold           array stall, freezes drain progress while high
//   fifo_drain_en  per-column FIFO pop / shift enable (bit 0 = column 0)
//   weight_shift   shadow-register shift enable in the array
//   weight_swap    one-cycle pulse, shadow -> active weights
//   drain_row      row index being shifted this cycle
//   state_dbg      current FSM state, for observation only
//
// Handshake: start/done behave as valid/ready. A drain request is accepted
// only on a cycle where start=1 and done=1 (IDLE). start in any other state is
// dropped, not queued. done falls the cycle after acceptance and rises again
// the cycle after the swap pulse.
// ----------------------------------------------------------------------------
module master_drain_fifo_control #(
    parameter int SYS_ARR_ROWS = 16,
    parameter int SYS_ARR_COLS = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    output logic                            done,
    input  logic [$clog2(SYS_ARR_COLS)-1:0] num_col,
    input  logic                            fill_done,
    input  logic                            hold,
    output logic [SYS_ARR_COLS-1:0]         fifo_drain_en,
    output logic                            weight_shift,
    output logic                            weight_swap,
    output logic [$clog2(SYS_ARR_ROWS)-1:0] drain_row,
    output logic [1:0]                      state_dbg
);

    localparam int ROW_W = $clog2(SYS_ARR_ROWS);
    localparam int COL_W = $clog2(SYS_ARR_COLS);
    // One extra bit so the last-row compare never depends on wraparound.
    localparam int CNT_W = ROW_W + 1;

    localparam logic [CNT_W-1:0]        LAST_ROW = CNT_W'(SYS_ARR_ROWS - 1);
    localparam logic [SYS_ARR_COLS-1:0] ALL_COLS = '1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_FILL = 2'd1,
        DRAIN     = 2'd2,
        SWAP      = 2'd3
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  count_q;

    logic [COL_W-1:0]        col_shamt;
    logic [SYS_ARR_COLS-1:0] col_mask;
    logic                    drain_active;

    // ------------------------------------------------------------------------
    // State and row counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= fill_done ? DRAIN : WAIT_FILL;
                    end
                end
                WAIT_FILL: begin
                    if (fill_done) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    // A stall freezes both the row index and the state.
                    if (!hold) begin
                        if (count_q == LAST_ROW) begin
                            state_q <= SWAP;
                            count_q <= '0;
                        end else begin
                            count_q <= count_q + CNT_W'(1);
                        end
                    end
                end
                SWAP: begin
                    // The swap is not stallable; the array takes it regardless.
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    count_q <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs, combinational from state / count / hold / num_col
    // ------------------------------------------------------------------------
    // Thermometer mask of the active columns: num_col+1 low bits set.
    assign col_shamt    = COL_W'(SYS_ARR_COLS - 1) - num_col;
    assign col_mask     = ALL_COLS >> col_shamt;

    assign drain_active = (state_q == DRAIN) && !hold;

    assign done          = (state_q == IDLE);
    assign fifo_drain_en = drain_active ? col_mask : '0;
    assign weight_shift  = drain_active;
    assign weight_swap   = (state_q == SWAP);
    assign drain_row     = (state_q == DRAIN) ? count_q[ROW_W-1:0] : '0;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_master_drain_fifo_control.sv
// ----------------------------------------------------------------------------
// Bench for master_drain_fifo_control (ROWS = COLS = 16).
// Each record holds the inputs for one cycle and the outputs expected during
// that cycle. Records are built from the documented latencies, then applied
// one per clock; expected words go into a queue when a record is driven and
// are popped and compared mid-cycle on the falling edge.
// ----------------------------------------------------------------------------
module tb_master_drain_fifo_control;

  localparam int ROWS = 16;
  localparam int COLS = 16;

  logic        clk;
  logic        reset;
  logic        start;
  logic        done;
  logic [3:0]  num_col;
  logic        fill_done;
  logic        hold;
  logic [15:0] fifo_drain_en;
  logic        weight_shift;
  logic        weight_swap;
  logic [3:0]  drain_row;
  logic [1:0]  state_dbg;

  master_drain_fifo_control #(
    .SYS_ARR_ROWS(ROWS),
    .SYS_ARR_COLS(COLS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .done         (done),
    .num_col      (num_col),
    .fill_done    (fill_done),
    .hold         (hold),
    .fifo_drain_en(fifo_drain_en),
    .weight_shift (weight_shift),
    .weight_swap  (weight_swap),
    .drain_row    (drain_row),
    .state_dbg    (state_dbg)
  );

  // ------------------------------------------------------------------------
  // Clock
  // ------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ------------------------------------------------------------------------
  // Vector table
  // ------------------------------------------------------------------------
  typedef struct {
    bit          st;
    bit          fd;
    bit          hd;
    bit          rs;
    logic [3:0]  nc;
    bit          e_done;
    logic [15:0] e_en;
    bit          e_shift;
    bit          e_swap;
    logic [3:0]  e_row;
  } vec_t;

  vec_t        vecs[$];
  logic [22:0] exp_q[$];
  int          total;
  int          bad;

  function automatic logic [15:0] col_mask(input int n);
    logic [31:0] one;
    one = 32'd1;
    return 16'((one << (n + 1)) - 32'd1);
  endfunction

  task automatic add(input bit st, input bit fd, input bit hd, input bit rs,
                     input logic [3:0] nc, input bit e_done, input logic [15:0] e_en,
                     input bit e_shift, input bit e_swap, input logic [3:0] e_row);
    vec_t v;
    v.st = st; v.fd = fd; v.hd = hd; v.rs = rs; v.nc = nc;
    v.e_done = e_done; v.e_en = e_en; v.e_shift = e_shift;
    v.e_swap = e_swap; v.e_row = e_row;
    vecs.push_back(v);
  endtask

  task automatic idle_v(input bit st, input bit fd, input logic [3:0] nc);
    add(st, fd, 1'b0, 1'b1, nc, 1'b1, 16'h0, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic wait_v(input bit fd, input logic [3:0] nc);
    add(1'b0, fd, 1'b0, 1'b1, nc, 1'b0, 16'h0, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic drain_v(input logic [3:0] nc, input int row, input bit hd, input bit st);
    add(st, 1'b1, hd, 1'b1, nc, 1'b0, hd ? 16'h0 : col_mask(int'(nc)),
        !hd, 1'b0, 4'(row));
  endtask

  task automatic drain_range(input logic [3:0] nc, input int first, input int last);
    for (int r = first; r <= last; r++) drain_v(nc, r, 1'b0, 1'b0);
  endtask

  task automatic swap_v(input logic [3:0] nc, input bit hd, input bit st);
    add(st, 1'b1, hd, 1'b1, nc, 1'b0, 16'h0, 1'b0, 1'b1, 4'd0);
  endtask

  // Plain tile: start@T0, rows T1..T16, swap T17, done T18.
  task automatic plain_tile(input logic [3:0] nc);
    idle_v(1'b1, 1'b1, nc);
    drain_range(nc, 0, ROWS - 1);
    swap_v(nc, 1'b0, 1'b0);
    idle_v(1'b0, 1'b1, nc);
  endtask

  task automatic build_table();
    logic [3:0] rnd_nc;
    // Reset state, including a start that reset must override.
    add(1'b0, 1'b1, 1'b0, 1'b0, 4'd15, 1'b1, 16'h0, 1'b0, 1'b0, 4'd0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 4'd15, 1'b1, 16'h0, 1'b0, 1'b0, 4'd0);
    idle_v(1'b0, 1'b1, 4'd15);

    // Full width and narrow tiles, plus the one-column boundary.
    plain_tile(4'd15);
    plain_tile(4'd3);
    plain_tile(4'd0);

    // Fill not ready at start: WAIT_FILL T1..T5, fill_done raised at T5.
    idle_v(1'b1, 1'b0, 4'd15);
    for (int t = 1; t <= 4; t++) wait_v(1'b0, 4'd15);
    wait_v(1'b1, 4'd15);
    drain_range(4'd15, 0, ROWS - 1);
    swap_v(4'd15, 1'b0, 1'b0);
    idle_v(1'b0, 1'b1, 4'd15);

    // Stall on row 4 for three cycles; hold during SWAP does not block it.
    idle_v(1'b1, 1'b1, 4'd7);
    drain_range(4'd7, 0, 3);
    for (int t = 0; t < 3; t++) drain_v(4'd7, 4, 1'b1, 1'b0);
    drain_range(4'd7, 4, ROWS - 1);
    swap_v(4'd7, 1'b1, 1'b0);
    idle_v(1'b0, 1'b1, 4'd7);

    // start re-asserted during DRAIN and SWAP is ignored.
    idle_v(1'b1, 1'b1, 4'd15);
    drain_range(4'd15, 0, 7);
    drain_v(4'd15, 8, 1'b0, 1'b1);
    drain_v(4'd15, 9, 1'b0, 1'b1);
    drain_range(4'd15, 10, ROWS - 1);
    swap_v(4'd15, 1'b0, 1'b1);
    idle_v(1'b0, 1'b1, 4'd15);
    idle_v(1'b0, 1'b1, 4'd15);

    // Reset at drain_row 7: idle next cycle, no swap; new start from row 0.
    idle_v(1'b1, 1'b1, 4'd15);
    drain_range(4'd15, 0, 6);
    add(1'b0, 1'b1, 1'b0, 1'b0, 4'd15, 1'b0, 16'hFFFF, 1'b1, 1'b0, 4'd7);
    idle_v(1'b0, 1'b1, 4'd15);
    plain_tile(4'd15);

    // One tile with a random column count.
    rnd_nc = 4'($urandom_range(1, 14));
    plain_tile(rnd_nc);
  endtask

  // ------------------------------------------------------------------------
  // Bounded wait for done after a start; reports an expired wait.
  // ------------------------------------------------------------------------
  task automatic wait_done(input int limit, input int want, output int cycles);
    cycles = 0;
    @(negedge clk);
    while (!done && cycles < limit) begin
      cycles++;
      @(negedge clk);
    end
    cycles++;
    total++;
    if (!done || cycles != want) begin
      bad++;
      $display("FAIL wait_done: done=%b after %0d cycles, want done=1 after %0d (limit %0d)",
               done, cycles, want, limit);
    end
  endtask

  // ------------------------------------------------------------------------
  // Driver, scoreboard and report
  // ------------------------------------------------------------------------
  initial begin
    logic [22:0] got;
    logic [22:0] e;
    int          n_cyc;
    total = 0;
    bad   = 0;
    reset = 1'b0; start = 1'b0; fill_done = 1'b0; hold = 1'b0; num_col = 4'd15;
    build_table();
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (done !== 1'b1 || fifo_drain_en !== 16'h0 || weight_shift !== 1'b0 ||
        weight_swap !== 1'b0 || drain_row !== 4'd0 || state_dbg !== 2'd0) begin
      bad++;
      $display("FAIL reset state: done=%b en=%h shift=%b swap=%b row=%0d state=%0d",
               done, fifo_drain_en, weight_shift, weight_swap, drain_row, state_dbg);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      reset     = vecs[i].rs;
      start     = vecs[i].st;
      fill_done = vecs[i].fd;
      hold      = vecs[i].hd;
      num_col   = vecs[i].nc;
      exp_q.push_back({vecs[i].e_done, vecs[i].e_en, vecs[i].e_shift,
                       vecs[i].e_swap, vecs[i].e_row});
      @(negedge clk);
      got = {done, fifo_drain_en, weight_shift, weight_swap, drain_row};
      e   = exp_q.pop_front();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL vec%0d: got done=%b en=%h shift=%b swap=%b row=%0d, want done=%b en=%h shift=%b swap=%b row=%0d",
                 i, got[22], got[21:6], got[5], got[4], got[3:0],
                 e[22], e[21:6], e[5], e[4], e[3:0]);
      end
      @(posedge clk);
      #1;
    end

    reset     = 1'b1;
    fill_done = 1'b1;
    hold      = 1'b0;
    num_col   = 4'd15;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(ROWS + 8, ROWS + 2, n_cyc);

    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard: %0d expected entries left unchecked", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
